gmii_rx_framer: RTL

//  Upstream of the DMA receiver. Strips the preamble/SFD from the GMII receive stream and packs frame bytes

---
 rtl/gmii_rx_framer_pkg.sv | 51 +++++
 rtl/gmii_rx_framer_if.sv | 25 ++
 rtl/gmii_rx_framer_rx_word_queue.sv | 63 ++++++
 rtl/gmii_rx_framer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_rx_framer_pkg.sv
// Shared definitions for the GMII receive framer.
//   - rx_state_t    : framer state encodings
//   - bit positions : phy word (IN_FRAME, NOT_LAST) and length word (ERR, TRUNC)
//   - qword_t       : one data-queue entry (last flag + 16-bit word)
//   - phy_word/len_word : build the 18-bit words written to the two FIFOs
package gmii_rx_framer_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_FLUSH,
    ST_DROP
  } rx_state_t;

  localparam int IN_FRAME_BIT  = 17;
  localparam int NOT_LAST_BIT  = 16;
  localparam int LEN_ERR_BIT   = 16;
  localparam int LEN_TRUNC_BIT = 15;
  localparam int TS_WORDS      = 4;
  localparam int TS_BYTES      = 8;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hd5;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } qword_t;

  function automatic logic [17:0] phy_word(input logic last, input logic [15:0] data);
    logic [17:0] w;
    w               = '0;
    w[IN_FRAME_BIT] = 1'b1;
    w[NOT_LAST_BIT] = ~last;
    w[15:0]         = data;
    return w;
  endfunction

  function automatic logic [17:0] len_word(input logic err, input logic trunc, input logic [10:0] len);
    logic [17:0] w;
    w                = '0;
    w[17]            = 1'b1;
    w[LEN_ERR_BIT]   = err;
    w[LEN_TRUNC_BIT] = trunc;
    w[10:0]          = len;
    return w;
  endfunction

endpackage

// File: rtl/gmii_rx_framer_if.sv
// Write-side bundle between the framer and its two downstream FIFOs.
//   phy_din/phy_wr_en  : 18-bit data word + strobe into the phy FIFO
//   phy_full/phy_afull : phy FIFO full / not enough room for a max frame
//   len_din/len_wr_en  : 18-bit length entry + strobe into the length FIFO
//   len_full           : length FIFO full
// master = framer side, slave = FIFO side.
interface gmii_rx_framer_if;
  logic [17:0] phy_din;
  logic        phy_wr_en;
  logic        phy_full;
  logic        phy_afull;
  logic [17:0] len_din;
  logic        len_wr_en;
  logic        len_full;

  modport master (
    output phy_din, phy_wr_en, len_din, len_wr_en,
    input  phy_full, phy_afull, len_full
  );

  modport slave (
    input  phy_din, phy_wr_en, len_din, len_wr_en,
    output phy_full, phy_afull, len_full
  );
endinterface

// File: rtl/gmii_rx_framer_rx_word_queue.sv
// rx_word_queue: small synchronous FIFO of qword_t entries.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset (empties queue)
//   push, push_word    : write request and entry
//   overwrite          : when full (and not popping) replace the tail instead of dropping
//   pop                : remove head (ignored when empty)
//   head_word          : current head entry
//   full, empty        : occupancy flags
// A push while full without pop and without overwrite is silently discarded.
module rx_word_queue
  import gmii_rx_framer_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic   sys_clk,
  input  logic   sys_rst_n,
  input  logic   push,
  input  logic   overwrite,
  input  qword_t push_word,
  input  logic   pop,
  output qword_t head_word,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(QDEPTH);

  qword_t         mem [QDEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic [AW:0]    fill;
  logic [AW-1:0]  tail_idx;
  logic           do_pop;
  logic           do_write;
  logic           do_over;

  assign fill     = wr_ptr_reg - rd_ptr_reg;
  assign full     = (fill == (AW+1)'(QDEPTH));
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign do_pop   = pop && !empty;
  assign do_write = push && (!full || do_pop);
  assign do_over  = push && full && !do_pop && overwrite;
  assign tail_idx = wr_ptr_reg[AW-1:0] - AW'(1);
  assign head_word = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (do_write) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_word;
    end else if (do_over) begin
      mem[tail_idx] <= push_word;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: strips preamble/SFD from the GMII rx stream, packs bytes into
// 16-bit words, prefixes each frame with a 4-word global_counter timestamp and
// writes the result to the phy FIFO, followed by one length entry per frame.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   gmii_rxd/rx_dv/rx_er : receive byte stream (already in sys_clk domain)
//   global_counter     : free-running timestamp, sampled at SFD
//   fifo               : phy/length FIFO write ports (master side)
//   rx_frame_cnt       : delivered frames (wraps)
//   rx_drop_cnt        : frames dropped whole (saturates)
module gmii_rx_framer
  import gmii_rx_framer_pkg::*;
#(
  parameter int MAX_BYTES = 2039,
  parameter int QDEPTH    = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  input  logic [63:0]      global_counter,
  gmii_rx_framer_if.master fifo,
  output logic [31:0]      rx_frame_cnt,
  output logic [15:0]      rx_drop_cnt
);

  rx_state_t   state_reg, state_next;
  logic        sfd_hit, drop_hit, data_byte, tail_step, len_fire;

  logic [63:0] ts_reg;
  logic [2:0]  ts_left_reg;
  logic [15:0] ts_words [TS_WORDS];
  logic [1:0]  ts_idx;
  logic [15:0] ts_word;

  logic [7:0]  half_byte_reg;
  logic        half_valid_reg;
  logic [15:0] pend_word_reg;
  logic        pend_valid_reg;
  logic [10:0] rx_bytes_reg;
  logic [10:0] byte_cnt_reg;
  logic        err_reg, trunc_reg, last_pushed_reg, last_written_reg;
  logic        at_max;

  qword_t      q_push_word, q_head;
  logic        q_push, q_overwrite, q_pop, q_full, q_empty, q_room;
  logic [1:0]  push_bytes;

  logic [17:0] phy_din_reg, len_din_reg;
  logic        phy_wr_en_reg, len_wr_en_reg;
  logic [31:0] frame_cnt_reg;
  logic [15:0] drop_cnt_reg;

  assign fifo.phy_din   = phy_din_reg;
  assign fifo.phy_wr_en = phy_wr_en_reg;
  assign fifo.len_din   = len_din_reg;
  assign fifo.len_wr_en = len_wr_en_reg;
  assign rx_frame_cnt   = frame_cnt_reg;
  assign rx_drop_cnt    = drop_cnt_reg;

  // ts_words[0] is the most significant word, written first.
  generate
    for (genvar gi = 0; gi < TS_WORDS; gi++) begin : g_ts
      assign ts_words[gi] = ts_reg[63 - 16*gi -: 16];
    end
  endgenerate
  assign ts_idx  = 2'(3'(TS_WORDS) - ts_left_reg);
  assign ts_word = ts_words[ts_idx];

  assign at_max = (rx_bytes_reg == 11'(MAX_BYTES));

  // ---------------- state machine ----------------
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state_reg <= ST_WAIT_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    sfd_hit    = 1'b0;
    drop_hit   = 1'b0;
    data_byte  = 1'b0;
    tail_step  = 1'b0;
    len_fire   = 1'b0;
    case (state_reg)
      ST_WAIT_IDLE: if (!gmii_rx_dv) state_next = ST_IDLE;
      ST_IDLE:      if (gmii_rx_dv)  state_next = ST_PREAMBLE;
      ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_next = ST_IDLE;
        end else if (gmii_rxd == SFD_BYTE) begin
          if (fifo.phy_afull || fifo.len_full) begin
            state_next = ST_DROP;
            drop_hit   = 1'b1;
          end else begin
            state_next = ST_DATA;
            sfd_hit    = 1'b1;
          end
        end else if (gmii_rxd != PREAMBLE_BYTE) begin
          state_next = ST_DROP;
          drop_hit   = 1'b1;
        end
      end
      ST_DATA: begin
        if (gmii_rx_dv) begin
          data_byte = 1'b1;
        end else begin
          tail_step  = 1'b1;
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // An odd-length tail may need a second push after the pending word.
        if (!last_pushed_reg) begin
          tail_step = 1'b1;
        end else if (last_written_reg) begin
          len_fire   = 1'b1;
          state_next = gmii_rx_dv ? ST_PREAMBLE : ST_IDLE;
        end
      end
      ST_DROP:  if (!gmii_rx_dv) state_next = ST_IDLE;
      default:  state_next = ST_WAIT_IDLE;
    endcase
  end

  // ---------------- queue push selection ----------------
  always_comb begin
    q_push      = 1'b0;
    q_overwrite = 1'b0;
    q_push_word = '0;
    push_bytes  = 2'd0;
    if (data_byte && !at_max && half_valid_reg && pend_valid_reg) begin
      q_push           = 1'b1;
      q_push_word.data = pend_word_reg;
      push_bytes       = 2'd2;
    end
    if (tail_step) begin
      q_push = 1'b1;
      if (pend_valid_reg) begin
        q_push_word.last = ~half_valid_reg;
        q_push_word.data = pend_word_reg;
        push_bytes       = 2'd2;
      end else if (half_valid_reg) begin
        q_push_word.last = 1'b1;
        q_push_word.data = {half_byte_reg, 8'h00};
        push_bytes       = 2'd1;
      end else begin
        q_push_word.last = 1'b1;
      end
      q_overwrite = q_push_word.last;
    end
  end

  assign q_pop  = !fifo.phy_full && !sfd_hit && (ts_left_reg == 3'd0) && !q_empty;
  assign q_room = !q_full || q_pop;

  rx_word_queue #(.QDEPTH(QDEPTH)) u_queue (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (q_push),
    .overwrite (q_overwrite),
    .push_word (q_push_word),
    .pop       (q_pop),
    .head_word (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // ---------------- byte packing ----------------
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      half_byte_reg   <= '0;
      half_valid_reg  <= 1'b0;
      pend_word_reg   <= '0;
      pend_valid_reg  <= 1'b0;
      rx_bytes_reg    <= '0;
      byte_cnt_reg    <= '0;
      err_reg         <= 1'b0;
      trunc_reg       <= 1'b0;
      last_pushed_reg <= 1'b0;
    end else begin
      if (sfd_hit) begin
        half_valid_reg  <= 1'b0;
        pend_valid_reg  <= 1'b0;
        rx_bytes_reg    <= '0;
        byte_cnt_reg    <= '0;
        err_reg         <= 1'b0;
        trunc_reg       <= 1'b0;
        last_pushed_reg <= 1'b0;
      end
      if (data_byte) begin
        if (gmii_rx_er) err_reg <= 1'b1;
        if (at_max) begin
          trunc_reg <= 1'b1;
        end else begin
          rx_bytes_reg <= rx_bytes_reg + 11'd1;
          if (!half_valid_reg) begin
            half_byte_reg  <= gmii_rxd;
            half_valid_reg <= 1'b1;
          end else begin
            pend_word_reg  <= {half_byte_reg, gmii_rxd};
            pend_valid_reg <= 1'b1;
            half_valid_reg <= 1'b0;
          end
        end
      end
      if (tail_step) begin
        if (pend_valid_reg)      pend_valid_reg <= 1'b0;
        else if (half_valid_reg) half_valid_reg <= 1'b0;
        if (q_push_word.last)    last_pushed_reg <= 1'b1;
      end
      if (q_push) begin
        if (q_room) begin
          byte_cnt_reg <= byte_cnt_reg + {9'd0, push_bytes};
        end else begin
          trunc_reg <= 1'b1;
          // The replaced tail is always a full non-last word of this frame.
          if (q_overwrite) byte_cnt_reg <= byte_cnt_reg - 11'd2 + {9'd0, push_bytes};
        end
      end
    end
  end

  // ---------------- phy write arbiter ----------------
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ts_reg           <= '0;
      ts_left_reg      <= '0;
      phy_din_reg      <= '0;
      phy_wr_en_reg    <= 1'b0;
      last_written_reg <= 1'b0;
    end else begin
      phy_wr_en_reg <= 1'b0;
      if (sfd_hit) begin
        ts_reg           <= global_counter;
        ts_left_reg      <= 3'(TS_WORDS);
        last_written_reg <= 1'b0;
      end else if (!fifo.phy_full) begin
        if (ts_left_reg != 3'd0) begin
          phy_wr_en_reg <= 1'b1;
          phy_din_reg   <= phy_word(1'b0, ts_word);
          ts_left_reg   <= ts_left_reg - 3'd1;
        end else if (!q_empty) begin
          phy_wr_en_reg <= 1'b1;
          phy_din_reg   <= phy_word(q_head.last, q_head.data);
          if (q_head.last) last_written_reg <= 1'b1;
        end
      end
    end
  end

  // ---------------- length entry and counters ----------------
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      len_din_reg   <= '0;
      len_wr_en_reg <= 1'b0;
      frame_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      len_wr_en_reg <= len_fire;
      if (len_fire) begin
        len_din_reg   <= len_word(err_reg, trunc_reg, 11'(TS_BYTES) + byte_cnt_reg);
        frame_cnt_reg <= frame_cnt_reg + 32'd1;
      end
      if (drop_hit && (drop_cnt_reg != 16'hffff)) drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

endmodule
